// File: rtl/writeback_buffer.sv
// writeback_buffer: coalescing FIFO of evicted dirty lines drained one at a time
// to the next memory level, with a combinational probe port for upstream misses.
module writeback_buffer #(
    parameter int ADDRBITS = 32,
    parameter int LINEBITS = 512,
    parameter int OFFBITS  = 6,
    parameter int DEPTH    = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wb_valid,
    input  logic [ADDRBITS-1:0]    wb_addr,
    input  logic [LINEBITS-1:0]    wb_data,
    output logic                   wb_ready,
    input  logic [ADDRBITS-1:0]    lookup_addr,
    output logic                   lookup_hit,
    output logic [LINEBITS-1:0]    lookup_data,
    output logic                   mem_request,
    output logic [ADDRBITS-1:0]    mem_addr,
    output logic [LINEBITS-1:0]    mem_data,
    input  logic                   mem_ack,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PTRBITS = $clog2(DEPTH);
    localparam int TAGBITS = ADDRBITS - OFFBITS;
    localparam logic [PTRBITS-1:0] PTR_ONE    = 1;
    localparam logic [PTRBITS:0]   COUNT_ONE  = 1;
    localparam logic [PTRBITS:0]   COUNT_FULL = (PTRBITS + 1)'(DEPTH);

    typedef enum logic {IDLE, REQ} state_t;

    state_t              state;
    logic [TAGBITS-1:0]  tags  [DEPTH];
    logic [LINEBITS-1:0] lines [DEPTH];
    logic [DEPTH-1:0]    valid;
    logic [PTRBITS-1:0]  head;
    logic [PTRBITS-1:0]  tail;

    logic [TAGBITS-1:0]  wb_tag;
    logic [TAGBITS-1:0]  lookup_tag;
    logic                accept;
    logic                pop;
    logic                append;
    logic                merge_hit;
    logic [PTRBITS-1:0]  merge_slot;
    logic [PTRBITS-1:0]  lookup_slot;
    logic [PTRBITS-1:0]  slot;
    logic                unused_offset;

    assign wb_tag        = wb_addr[ADDRBITS-1:OFFBITS];
    assign lookup_tag    = lookup_addr[ADDRBITS-1:OFFBITS];
    assign unused_offset = ^{wb_addr[OFFBITS-1:0], lookup_addr[OFFBITS-1:0]};

    assign empty    = (count == '0);
    assign full     = (count == COUNT_FULL);
    assign wb_ready = !full;
    assign accept   = wb_valid && wb_ready;
    assign pop      = (state == REQ) && mem_ack;
    assign append   = accept && !merge_hit;

    assign mem_addr    = {tags[head], {OFFBITS{1'b0}}};
    assign mem_data    = lines[head];
    assign lookup_data = lookup_hit ? lines[lookup_slot] : '0;

    // Walk entries oldest to youngest so the youngest match wins; the head is
    // excluded from coalescing while its write-back is in flight.
    always_comb begin
        merge_hit   = 1'b0;
        merge_slot  = '0;
        lookup_hit  = 1'b0;
        lookup_slot = '0;
        slot        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head + PTRBITS'(i);
            if (valid[slot] && (tags[slot] == wb_tag) && !((i == 0) && (state == REQ))) begin
                merge_hit  = 1'b1;
                merge_slot = slot;
            end
            if (valid[slot] && (tags[slot] == lookup_tag)) begin
                lookup_hit  = 1'b1;
                lookup_slot = slot;
            end
        end
    end

    // Line storage: coalesce in place or write the tail slot; contents survive reset.
    always_ff @(posedge clock) begin
        if (reset && accept) begin
            if (merge_hit) begin
                lines[merge_slot] <= wb_data;
            end else begin
                tags[tail]  <= wb_tag;
                lines[tail] <= wb_data;
            end
        end
    end

    // Occupancy bookkeeping and the two-state drain machine with registered request.
    always_ff @(posedge clock) begin
        if (!reset) begin
            valid       <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            state       <= IDLE;
            mem_request <= 1'b0;
        end else begin
            if (append) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_ONE;
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_ONE;
            end
            case ({append, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state       <= REQ;
                        mem_request <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state       <= IDLE;
                        mem_request <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    mem_request <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: directed scenarios followed by random traffic, every cycle
// checked against a queue-based model of the buffer's externally visible behaviour.
module tb_writeback_buffer;

    localparam int ADDRBITS = 32;
    localparam int LINEBITS = 512;
    localparam int OFFBITS  = 6;
    localparam int DEPTH    = 4;
    localparam int CNTBITS  = $clog2(DEPTH) + 1;

    logic                clock = 1'b0;
    logic                reset;
    logic                wb_valid;
    logic [ADDRBITS-1:0] wb_addr;
    logic [LINEBITS-1:0] wb_data;
    logic                wb_ready;
    logic [ADDRBITS-1:0] lookup_addr;
    logic                lookup_hit;
    logic [LINEBITS-1:0] lookup_data;
    logic                mem_request;
    logic [ADDRBITS-1:0] mem_addr;
    logic [LINEBITS-1:0] mem_data;
    logic                mem_ack;
    logic [CNTBITS-1:0]  count;
    logic                empty;
    logic                full;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [ADDRBITS-OFFBITS-1:0] tag;
        logic [LINEBITS-1:0]         data;
    } entry_t;

    entry_t q[$];
    bit     busy = 1'b0;

    writeback_buffer #(
        .ADDRBITS(ADDRBITS),
        .LINEBITS(LINEBITS),
        .OFFBITS (OFFBITS),
        .DEPTH   (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .wb_ready   (wb_ready),
        .lookup_addr(lookup_addr),
        .lookup_hit (lookup_hit),
        .lookup_data(lookup_data),
        .mem_request(mem_request),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_ack    (mem_ack),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    function automatic logic [LINEBITS-1:0] rand_line();
        logic [LINEBITS-1:0] v;
        v = '0;
        for (int i = 0; i < LINEBITS / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string tag, input logic [LINEBITS-1:0] obs, input logic [LINEBITS-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        int                  n;
        logic                hit;
        logic [LINEBITS-1:0] ldata;
        n     = q.size();
        hit   = 1'b0;
        ldata = '0;
        for (int j = 0; j < n; j++) begin
            if (q[j].tag == lookup_addr[ADDRBITS-1:OFFBITS]) begin
                hit   = 1'b1;
                ldata = q[j].data;
            end
        end
        check("count", count, n);
        check("empty", empty, n == 0);
        check("full", full, n == DEPTH);
        check("wb_ready", wb_ready, n < DEPTH);
        check("mem_request", mem_request, busy);
        check("lookup_hit", lookup_hit, hit);
        check("lookup_data", lookup_data, ldata);
        if (busy) begin
            check("mem_addr", mem_addr, {q[0].tag, {OFFBITS{1'b0}}});
            check("mem_data", mem_data, q[0].data);
        end
    endtask

    task automatic model_edge();
        int     n;
        bit     acc;
        bit     popping;
        int     j;
        entry_t e;
        n       = q.size();
        acc     = wb_valid && (n < DEPTH);
        popping = busy && mem_ack;
        j       = -1;
        if (!reset) begin
            q.delete();
            busy = 1'b0;
        end else begin
            if (acc) begin
                for (int k = (busy ? 1 : 0); k < n; k++)
                    if (q[k].tag == wb_addr[ADDRBITS-1:OFFBITS]) j = k;
                if (j >= 0) begin
                    q[j].data = wb_data;
                end else begin
                    e.tag  = wb_addr[ADDRBITS-1:OFFBITS];
                    e.data = wb_data;
                    q.push_back(e);
                end
            end
            if (popping) begin
                q.delete(0);
                busy = 1'b0;
            end else if (!busy && n > 0) begin
                busy = 1'b1;
            end
        end
    endtask

    task automatic apply_stimulus(input bit rst_n, input bit v, input logic [ADDRBITS-1:0] a,
                                  input logic [LINEBITS-1:0] d, input bit ack,
                                  input logic [ADDRBITS-1:0] look);
        reset       = rst_n;
        wb_valid    = v;
        wb_addr     = a;
        wb_data     = d;
        mem_ack     = ack;
        lookup_addr = look;
        @(negedge clock);
        check_output();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    // Directed scenarios, then randomized traffic with occasional resets.
    initial begin
        logic [LINEBITS-1:0] d1, d2, d3, d4;
        logic [ADDRBITS-1:0] a;
        d1 = rand_line();
        d2 = rand_line();
        d3 = rand_line();
        d4 = rand_line();
        reset       = 1'b0;
        wb_valid    = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
        mem_ack     = 1'b0;
        lookup_addr = '0;
        @(posedge clock);
        model_edge();
        #1;
        apply_stimulus(0, 1, 32'h1000, d1, 1, 32'h1000);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ready", wb_ready, 1);
        check("rst_hit", lookup_hit, 0);
        check("rst_count", count, 0);
        check("rst_req", mem_request, 0);

        $display("[TB] single line");
        apply_stimulus(1, 1, 32'h1000, d1, 0, 32'h1000);
        check("s1_hit", lookup_hit, 1);
        check("s1_req_not_yet", mem_request, 0);
        apply_stimulus(1, 0, 32'h0, '0, 0, 32'h1000);
        check("s1_req", mem_request, 1);
        check("s1_addr", mem_addr, 32'h1000);
        check("s1_data", mem_data, d1);
        apply_stimulus(1, 0, 32'h0, '0, 1, 32'h1000);
        check("s1_count", count, 0);
        check("s1_empty", empty, 1);
        check("s1_nohit", lookup_hit, 0);
        apply_stimulus(1, 0, 32'h0, '0, 0, 32'h0);

        $display("[TB] fill");
        for (int i = 0; i < 4; i++)
            apply_stimulus(1, 1, 32'h4000 + 32'(i * 64), rand_line(), 0, 32'h4080);
        check("fill_full", full, 1);
        check("fill_ready", wb_ready, 0);
        apply_stimulus(1, 1, 32'h5000, d2, 0, 32'h5000);
        check("fill_5th_count", count, 4);
        apply_stimulus(1, 1, 32'h5000, d2, 1, 32'h5000);
        check("fill_pop_count", count, 3);
        check("fill_ready_back", wb_ready, 1);
        for (int i = 0; i < 8; i++) apply_stimulus(1, 0, 32'h0, '0, 1, 32'h4040);
        check("fill_drained", empty, 1);

        $display("[TB] coalesce");
        apply_stimulus(1, 1, 32'h2000, d1, 0, 32'h3000);
        apply_stimulus(1, 1, 32'h3000, d2, 0, 32'h3000);
        apply_stimulus(1, 1, 32'h3008, d3, 0, 32'h3000);
        check("co_count", count, 2);
        check("co_lookup", lookup_data, d3);
        for (int i = 0; i < 6; i++) apply_stimulus(1, 0, 32'h0, '0, 1, 32'h3000);

        $display("[TB] locked head");
        apply_stimulus(1, 1, 32'h2000, d1, 0, 32'h2000);
        apply_stimulus(1, 0, 32'h0, '0, 0, 32'h2000);
        check("lk_req", mem_request, 1);
        apply_stimulus(1, 1, 32'h2000, d4, 0, 32'h2000);
        check("lk_count", count, 2);
        check("lk_lookup", lookup_data, d4);
        check("lk_head_data", mem_data, d1);
        for (int i = 0; i < 6; i++) apply_stimulus(1, 0, 32'h0, '0, 1, 32'h2000);

        $display("[TB] simultaneous and wrap");
        apply_stimulus(1, 1, 32'h7000, rand_line(), 0, 32'h0);
        apply_stimulus(1, 1, 32'h7040, rand_line(), 0, 32'h0);
        apply_stimulus(1, 1, 32'h7080, rand_line(), 1, 32'h0);
        check("sim_count", count, 2);
        for (int i = 0; i < 10; i++)
            apply_stimulus(1, 1, 32'h8000 + 32'(i * 64), rand_line(), i[0], 32'h8000 + 32'(i * 64));
        for (int i = 0; i < 16; i++) apply_stimulus(1, 0, 32'h0, '0, 1, 32'h0);

        $display("[TB] reset mid request");
        apply_stimulus(1, 1, 32'h9000, rand_line(), 0, 32'h9000);
        apply_stimulus(1, 0, 32'h0, '0, 0, 32'h9000);
        check("mr_req", mem_request, 1);
        apply_stimulus(0, 0, 32'h0, '0, 0, 32'h9000);
        check("mr_req_drop", mem_request, 0);
        check("mr_count", count, 0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1, 0, 32'h0, '0, 1, 32'h9000);
            check("mr_quiet", mem_request, 0);
        end

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            a = 32'h6000 + 32'($urandom_range(0, 5) * 64) + 32'($urandom_range(0, 63));
            apply_stimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 6), a,
                           rand_line(), $urandom_range(0, 1) == 1,
                           32'h6000 + 32'($urandom_range(0, 6) * 64) + 32'($urandom_range(0, 63)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 Parameter ADDRBITS, default 32: byte address width.
REQ-002 Parameter LINEBITS, default 512: cache line data width.
REQ-003 Parameter OFFBITS, default 6: line-offset bits, ignored in address compares.
REQ-004 Parameter DEPTH, default 4: entry count, power of two, at least 2.
REQ-005 clock  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-007 wb_valid  in  1  upstream cache offers an evicted dirty line.
REQ-008 wb_addr  in  ADDRBITS  line address of the offered line.
REQ-009 wb_data  in  LINEBITS  line data of the offered line.
REQ-010 wb_ready  out  1  buffer accepts the offer this cycle.
REQ-011 lookup_addr  in  ADDRBITS  address of an upstream miss being probed.
REQ-012 lookup_hit  out  1  a pending entry matches lookup_addr.
REQ-013 lookup_data  out  LINEBITS  data of the matching entry, zero when lookup_hit=0.
REQ-014 mem_request  out  1  write request to the next level.
REQ-015 mem_addr  out  ADDRBITS  address of the head entry, offset bits zero.
REQ-016 mem_data  out  LINEBITS  data of the head entry.
REQ-017 mem_ack  in  1  next level has accepted the write.
REQ-018 count  out  $clog2(DEPTH)+1  number of occupied entries.
REQ-019 empty / full  out  1 each  count==0 / count==DEPTH.

Function
REQ-020 Buffer SHALL be a circular FIFO with head and tail pointers that wrap modulo DEPTH, plus a valid bit per entry.
REQ-021 wb_ready SHALL equal !full combinationally; an accept occurs on any edge where wb_valid && wb_ready.
REQ-022 Coalescing: an accept whose address tag (bits ADDRBITS-1:OFFBITS) matches a valid non-head entry SHALL overwrite that entry's data in place, leaving count and tail unchanged.
REQ-023 Coalescing into the head entry SHALL also occur when drain state is IDLE; in REQ state the head is locked and the line is appended as a new entry.
REQ-024 A non-coalesced accept SHALL write the tail entry, advance tail, and increment count.
REQ-025 Drain FSM states: IDLE, REQ.
REQ-026 IDLE goes to REQ when !empty; otherwise it stays in IDLE.
REQ-027 REQ holds while !mem_ack; on mem_ack it pops the head, advances head, decrements count, and goes to IDLE.
REQ-028 mem_request SHALL be registered, high exactly while in REQ.
REQ-029 mem_addr and mem_data SHALL be stable from REQ entry until the mem_ack edge.
REQ-030 Drain latency SHALL be as follows: first entry written at edge N gives mem_request high from edge N+1.
REQ-031 Back-to-back drains SHALL insert exactly one IDLE cycle between requests.
REQ-032 Accept and pop on the same edge SHALL leave count unchanged and move both pointers.
REQ-033 When full, wb_ready=0 even if a pop occurs that cycle; no same-cycle refill.
REQ-034 mem_ack outside REQ SHALL be ignored.
REQ-035 Lookup SHALL be combinational over all valid entries; with multiple matches, the youngest entry (nearest tail) wins.
REQ-036 Lookup SHALL NOT see a same-cycle accept; data becomes visible the edge after the accept.
REQ-037 An entry popped on edge N SHALL no longer hit from edge N onward.

Reset
REQ-038 When reset=0 at an edge: all valid bits 0, head=tail=0, count=0, state IDLE, mem_request=0.
REQ-039 Following that edge, empty=1, full=0, wb_ready=1, lookup_hit=0.
REQ-040 Reset mid-REQ SHALL drop mem_request at that edge and discard all entries without write-back; entry data contents need not be cleared.

Verification
REQ-041 Single line: reset, then accept A=0x1000 with D1 -> mem_request high next cycle with mem_addr 0x1000 and D1; after mem_ack, count=0 and empty=1.
REQ-042 Fill: 4 accepts with mem_ack held low -> full=1, wb_ready=0, 5th offer not accepted; one mem_ack -> count=3, then wb_ready=1.
REQ-043 Coalesce: accept 0x2000/D1, then 0x3000/D2, then 0x3000/D3 while 0x2000 is draining -> count=2; 0x3000 is later written with D3 only.
REQ-044 Locked head: while 0x2000 is in REQ, accept 0x2000/D4 -> count=2; lookup 0x2000 returns D4; two writes to 0x2000 in order D1, D4.
REQ-045 Simultaneous: count=2 with accept and mem_ack on the same edge -> count stays 2; FIFO order preserved across pointer wrap after 10 entries.
REQ-046 Reset mid-REQ: reset=0 while mem_request=1 -> mem_request=0 and count=0 after the edge; no further requests issued.
